// File: rtl/pmod_als_pkg.sv
// Shared definitions for the Pmod ALS light-sensor emulator: frame layout and
// responder state encoding.
package pmod_als_pkg;

   localparam int ALS_FRAME_BITS  = 16;
   localparam int ALS_LEAD_ZEROS  = 3;
   localparam int ALS_TRAIL_ZEROS = 5;

   typedef enum logic [1:0] {
      ST_ARM    = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2
   } als_state_e;

   function automatic logic [ALS_FRAME_BITS-1:0] als_frame(input logic [7:0] level);
      return {{ALS_LEAD_ZEROS{1'b0}}, level, {ALS_TRAIL_ZEROS{1'b0}}};
   endfunction

endpackage

// File: rtl/pmod_sync.sv
// Flop-chain synchronizer for a single pin; every stage resets to RESET_VALUE
// so a line that idles at that level produces no spurious edge at reset.
module pmod_sync #(
   parameter int   STAGES      = 2,
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= {STAGES{RESET_VALUE}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/pmod_als_spi_responder.sv
// Pmod ALS emulator: shifts {3'b0, light, 5'b0} out on sdo, one bit per
// synchronized sck falling edge while cs is low, and flags done/abort/overrun.
module pmod_als_spi_responder
   import pmod_als_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cs,
   input  logic       sck,
   input  logic [7:0] light,
   output logic       sdo,
   output logic       busy,
   output logic       frame_done,
   output logic       frame_abort,
   output logic       overrun
);

   // ARM waits until the reset-level 1s have been flushed out of the whole
   // edge pipeline before trusting the cs level.
   localparam int ARM_SETTLE = SYNC_STAGES + 2;
   localparam int ARM_W      = $clog2(ARM_SETTLE + 1);

   logic cs_sync;
   logic sck_sync;

   pmod_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_cs_sync (
      .clock (clock),
      .reset (reset),
      .din   (cs),
      .dout  (cs_sync)
   );

   pmod_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sck_sync (
      .clock (clock),
      .reset (reset),
      .din   (sck),
      .dout  (sck_sync)
   );

   logic             cs_hist_q, cs_hist_d;
   logic             sck_hist_q, sck_hist_d;
   logic             cs_fall_q, cs_fall_d;
   logic             cs_rise_q, cs_rise_d;
   logic             sck_fall_q, sck_fall_d;
   logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;

   always_comb begin
      cs_hist_d  = cs_sync;
      sck_hist_d = sck_sync;
      cs_fall_d  = cs_hist_q & ~cs_sync;
      cs_rise_d  = ~cs_hist_q & cs_sync;
      sck_fall_d = sck_hist_q & ~sck_sync;
      arm_cnt_d  = arm_cnt_q;
      if (arm_cnt_q != ARM_W'(ARM_SETTLE)) begin
         arm_cnt_d = arm_cnt_q + ARM_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cs_hist_q  <= 1'b1;
         sck_hist_q <= 1'b1;
         cs_fall_q  <= 1'b0;
         cs_rise_q  <= 1'b0;
         sck_fall_q <= 1'b0;
         arm_cnt_q  <= '0;
      end else begin
         cs_hist_q  <= cs_hist_d;
         sck_hist_q <= sck_hist_d;
         cs_fall_q  <= cs_fall_d;
         cs_rise_q  <= cs_rise_d;
         sck_fall_q <= sck_fall_d;
         arm_cnt_q  <= arm_cnt_d;
      end
   end

   als_state_e                state_q;
   logic                      sdo_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      abort_q;
   logic                      overrun_q;
   logic [4:0]                bit_cnt_q;
   logic [7:0]                light_q;

   logic [ALS_FRAME_BITS-1:0] frame_word;
   logic [3:0]                bit_idx;
   logic                      frame_full;
   logic                      arm_settled;

   always_comb begin
      frame_word  = als_frame(light_q);
      bit_idx     = 4'(ALS_FRAME_BITS - 1) - bit_cnt_q[3:0];
      frame_full  = (bit_cnt_q == 5'(ALS_FRAME_BITS));
      arm_settled = (arm_cnt_q == ARM_W'(ARM_SETTLE));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_ARM;
         sdo_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         overrun_q <= 1'b0;
         bit_cnt_q <= '0;
         light_q   <= '0;
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         case (state_q)
            ST_ARM: begin
               sdo_q  <= 1'b0;
               busy_q <= 1'b0;
               if (arm_settled && cs_hist_q) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               sdo_q  <= 1'b0;
               busy_q <= 1'b0;
               if (cs_fall_q) begin
                  light_q   <= light;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // cs rise takes priority over a coincident sck fall.
               if (cs_rise_q) begin
                  sdo_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= frame_full;
                  abort_q <= ~frame_full;
                  state_q <= ST_IDLE;
               end else if (sck_fall_q) begin
                  if (bit_cnt_q < 5'(ALS_FRAME_BITS)) begin
                     sdo_q     <= frame_word[bit_idx];
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end else begin
                     sdo_q     <= 1'b0;
                     overrun_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_ARM;
               sdo_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sdo         = sdo_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_abort = abort_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_pmod_als_spi_responder.sv
// Self-checking bench for pmod_als_spi_responder: drives SPI frames like the
// codebase master (8-clock sck half period) and compares against light*32.
module tb_pmod_als_spi_responder;

   localparam int SYNC = 2;
   localparam int HALF = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cs    = 1'b1;
   logic       sck   = 1'b1;
   logic [7:0] light = 8'h00;
   logic       sdo;
   logic       busy;
   logic       frame_done;
   logic       frame_abort;
   logic       overrun;

   pmod_als_spi_responder #(.SYNC_STAGES(SYNC)) dut (
      .clock       (clock),
      .reset       (reset),
      .cs          (cs),
      .sck         (sck),
      .light       (light),
      .sdo         (sdo),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_abort (frame_abort),
      .overrun     (overrun)
   );

   always #5 clock = ~clock;

   int checks    = 0;
   int errors    = 0;
   int done_cnt  = 0;
   int abort_cnt = 0;

   // Counting high cycles also catches pulses wider than one clock.
   always @(negedge clock) begin
      if (frame_done)  done_cnt  = done_cnt + 1;
      if (frame_abort) abort_cnt = abort_cnt + 1;
   end

   function automatic logic [15:0] model_frame(input logic [7:0] lt);
      return 16'(lt) * 16'd32;
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_frame(input int nbits, input bit coincide_end, input int change_at,
                           input logic [7:0] new_light, input int gap,
                           output logic [31:0] got, output logic sdo_pre,
                           output logic busy_mid, output logic busy_after);
      got = '0;
      cs  = 1'b0;
      wait_clks(HALF);
      sdo_pre  = sdo;
      busy_mid = busy;
      for (int i = 0; i < nbits; i++) begin
         if (i == change_at) light = new_light;
         sck = 1'b0;
         if (coincide_end && i == nbits - 1) cs = 1'b1;
         wait_clks(HALF);
         got = {got[30:0], sdo};
         sck = 1'b1;
         wait_clks(HALF);
      end
      cs = 1'b1;
      wait_clks(gap);
      busy_after = busy;
   endtask

   task automatic test_reset();
      wait_clks(2);
      checks++; if (sdo !== 1'b0)         begin errors++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
      checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", frame_abort); end
      checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      reset = 1'b0;
      wait_clks(10);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
      checks++; if (sdo !== 1'b0)  begin errors++; $display("FAIL post_reset_sdo got=%b exp=0", sdo); end
      $display("reset: sdo=%b busy=%b overrun=%b", sdo, busy, overrun);
   endtask

   task automatic test_basic();
      logic [31:0] got;
      logic        sp, bm, ba;
      int          d0, a0;
      d0 = done_cnt; a0 = abort_cnt;
      light = 8'hA5;
      do_frame(16, 1'b0, -1, 8'h00, HALF, got, sp, bm, ba);
      $display("frame basic light=%h got=%h exp=%h", 8'hA5, got[15:0], model_frame(8'hA5));
      checks++; if (got[15:0] !== model_frame(8'hA5)) begin errors++; $display("FAIL basic_value got=%h exp=%h", got[15:0], model_frame(8'hA5)); end
      checks++; if (sp !== 1'b0)               begin errors++; $display("FAIL basic_sdo_before_first got=%b exp=0", sp); end
      checks++; if (bm !== 1'b1)               begin errors++; $display("FAIL basic_busy_mid got=%b exp=1", bm); end
      checks++; if (ba !== 1'b0)               begin errors++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
      checks++; if (done_cnt - d0 !== 1)       begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
      checks++; if (abort_cnt - a0 !== 0)      begin errors++; $display("FAIL basic_abort_pulses got=%0d exp=0", abort_cnt - a0); end
      checks++; if (overrun !== 1'b0)          begin errors++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
      checks++; if (sdo !== 1'b0)              begin errors++; $display("FAIL basic_sdo_after got=%b exp=0", sdo); end
   endtask

   task automatic test_light_change();
      logic [31:0] got;
      logic        sp, bm, ba;
      light = 8'hFF;
      do_frame(16, 1'b0, 4, 8'h00, HALF, got, sp, bm, ba);
      $display("frame light_change got=%h exp=%h", got[15:0], model_frame(8'hFF));
      checks++; if (got[15:0] !== model_frame(8'hFF)) begin errors++; $display("FAIL light_change_first got=%h exp=%h", got[15:0], model_frame(8'hFF)); end
      do_frame(16, 1'b0, -1, 8'h00, HALF, got, sp, bm, ba);
      $display("frame light_change_next got=%h exp=%h", got[15:0], model_frame(8'h00));
      checks++; if (got[15:0] !== model_frame(8'h00)) begin errors++; $display("FAIL light_change_next got=%h exp=%h", got[15:0], model_frame(8'h00)); end
   endtask

   task automatic test_random();
      logic [31:0] got;
      logic        sp, bm, ba;
      logic [7:0]  lt;
      int          d0;
      d0 = done_cnt;
      for (int n = 0; n < 6; n++) begin
         lt    = 8'($urandom);
         light = lt;
         do_frame(16, 1'b0, -1, 8'h00, HALF + int'($urandom_range(0, 6)), got, sp, bm, ba);
         $display("frame random light=%h got=%h exp=%h", lt, got[15:0], model_frame(lt));
         checks++; if (got[15:0] !== model_frame(lt)) begin errors++; $display("FAIL random_value got=%h exp=%h", got[15:0], model_frame(lt)); end
      end
      checks++; if (done_cnt - d0 !== 6) begin errors++; $display("FAIL random_done_pulses got=%0d exp=6", done_cnt - d0); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      logic        sp, bm, ba;
      logic [7:0]  lt;
      int          d0;
      d0 = done_cnt;
      for (int n = 0; n < 4; n++) begin
         lt    = 8'($urandom);
         light = lt;
         do_frame(16, 1'b0, -1, 8'h00, SYNC + 1, got, sp, bm, ba);
         $display("frame back_to_back light=%h got=%h exp=%h", lt, got[15:0], model_frame(lt));
         checks++; if (got[15:0] !== model_frame(lt)) begin errors++; $display("FAIL b2b_value got=%h exp=%h", got[15:0], model_frame(lt)); end
      end
      wait_clks(HALF);
      checks++; if (done_cnt - d0 !== 4) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=4", done_cnt - d0); end
   endtask

   task automatic test_abort();
      logic [31:0] got;
      logic        sp, bm, ba;
      logic [7:0]  lt;
      logic [15:0] exp_full;
      int          d0, a0;
      d0 = done_cnt; a0 = abort_cnt;
      lt = 8'($urandom);
      light = lt;
      exp_full = model_frame(lt);
      do_frame(9, 1'b0, -1, 8'h00, HALF, got, sp, bm, ba);
      $display("frame abort light=%h got9=%h exp9=%h", lt, got[8:0], exp_full[15:7]);
      checks++; if (got[8:0] !== exp_full[15:7]) begin errors++; $display("FAIL abort_bits got=%h exp=%h", got[8:0], exp_full[15:7]); end
      checks++; if (abort_cnt - a0 !== 1)        begin errors++; $display("FAIL abort_pulses got=%0d exp=1", abort_cnt - a0); end
      checks++; if (done_cnt - d0 !== 0)         begin errors++; $display("FAIL abort_done_pulses got=%0d exp=0", done_cnt - d0); end
      checks++; if (sdo !== 1'b0)                begin errors++; $display("FAIL abort_sdo_after got=%b exp=0", sdo); end
      checks++; if (ba !== 1'b0)                 begin errors++; $display("FAIL abort_busy_after got=%b exp=0", ba); end
      lt = 8'($urandom);
      light = lt;
      do_frame(16, 1'b0, -1, 8'h00, HALF, got, sp, bm, ba);
      $display("frame after_abort light=%h got=%h exp=%h", lt, got[15:0], model_frame(lt));
      checks++; if (got[15:0] !== model_frame(lt)) begin errors++; $display("FAIL after_abort_value got=%h exp=%h", got[15:0], model_frame(lt)); end
      checks++; if (done_cnt - d0 !== 1)          begin errors++; $display("FAIL after_abort_done got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_coincident();
      logic [31:0] got;
      logic        sp, bm, ba;
      logic [7:0]  lt;
      logic [15:0] exp_full;
      int          d0, a0;
      d0 = done_cnt; a0 = abort_cnt;
      lt = 8'($urandom);
      light = lt;
      exp_full = model_frame(lt);
      do_frame(16, 1'b1, -1, 8'h00, HALF, got, sp, bm, ba);
      $display("frame coincident light=%h got15=%h exp15=%h", lt, got[15:1], exp_full[15:1]);
      checks++; if (got[15:1] !== exp_full[15:1]) begin errors++; $display("FAIL coincident_bits got=%h exp=%h", got[15:1], exp_full[15:1]); end
      checks++; if (abort_cnt - a0 !== 1)          begin errors++; $display("FAIL coincident_abort got=%0d exp=1", abort_cnt - a0); end
      checks++; if (done_cnt - d0 !== 0)           begin errors++; $display("FAIL coincident_done got=%0d exp=0", done_cnt - d0); end
      checks++; if (sdo !== 1'b0)                  begin errors++; $display("FAIL coincident_sdo got=%b exp=0", sdo); end
   endtask

   task automatic test_overrun();
      logic [31:0] got;
      logic        sp, bm, ba;
      int          d0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_before got=%b exp=0", overrun); end
      d0 = done_cnt;
      light = 8'h81;
      do_frame(18, 1'b0, -1, 8'h00, HALF, got, sp, bm, ba);
      $display("frame overrun got16=%h tail=%b overrun=%b", got[17:2], got[1:0], overrun);
      checks++; if (got[17:2] !== model_frame(8'h81)) begin errors++; $display("FAIL overrun_bits got=%h exp=%h", got[17:2], model_frame(8'h81)); end
      checks++; if (got[1:0] !== 2'b00)               begin errors++; $display("FAIL overrun_tail got=%b exp=00", got[1:0]); end
      checks++; if (overrun !== 1'b1)                 begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
      checks++; if (done_cnt - d0 !== 1)              begin errors++; $display("FAIL overrun_done got=%0d exp=1", done_cnt - d0); end
      light = 8'h3C;
      do_frame(16, 1'b0, -1, 8'h00, HALF, got, sp, bm, ba);
      $display("frame after_overrun got=%h exp=%h overrun=%b", got[15:0], model_frame(8'h3C), overrun);
      checks++; if (got[15:0] !== model_frame(8'h3C)) begin errors++; $display("FAIL after_overrun_value got=%h exp=%h", got[15:0], model_frame(8'h3C)); end
      checks++; if (overrun !== 1'b1)                 begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] got;
      logic        sp, bm, ba;
      logic [7:0]  lt;
      logic [15:0] exp_full;
      logic [4:0]  first5;
      int          bad, d0, a0;
      lt = 8'($urandom);
      light = lt;
      exp_full = model_frame(lt);
      first5 = '0;
      cs = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < 5; i++) begin
         sck = 1'b0; wait_clks(HALF);
         first5 = {first5[3:0], sdo};
         sck = 1'b1; wait_clks(HALF);
      end
      checks++; if (first5 !== exp_full[15:11]) begin errors++; $display("FAIL reset_mid_first5 got=%b exp=%b", first5, exp_full[15:11]); end
      reset = 1'b1;
      #1;
      checks++; if (sdo !== 1'b0)     begin errors++; $display("FAIL reset_mid_sdo got=%b exp=0", sdo); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_mid_overrun got=%b exp=0", overrun); end
      wait_clks(2);
      reset = 1'b0;
      d0 = done_cnt; a0 = abort_cnt;
      bad = 0;
      for (int i = 0; i < 11; i++) begin
         sck = 1'b0; wait_clks(HALF);
         if (sdo !== 1'b0 || busy !== 1'b0) bad++;
         sck = 1'b1; wait_clks(HALF);
      end
      cs = 1'b1;
      wait_clks(HALF);
      $display("frame reset_mid light=%h first5=%b bad_after_reset=%0d", lt, first5, bad);
      checks++; if (bad !== 0)                       begin errors++; $display("FAIL reset_mid_quiet got=%0d exp=0", bad); end
      checks++; if (done_cnt - d0 + abort_cnt - a0 !== 0) begin errors++; $display("FAIL reset_mid_pulses got=%0d exp=0", done_cnt - d0 + abort_cnt - a0); end
      lt = 8'($urandom);
      light = lt;
      do_frame(16, 1'b0, -1, 8'h00, HALF, got, sp, bm, ba);
      $display("frame after_reset light=%h got=%h exp=%h", lt, got[15:0], model_frame(lt));
      checks++; if (got[15:0] !== model_frame(lt)) begin errors++; $display("FAIL after_reset_value got=%h exp=%h", got[15:0], model_frame(lt)); end
      checks++; if (done_cnt - d0 !== 1)          begin errors++; $display("FAIL after_reset_done got=%0d exp=1", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_light_change();
      test_random();
      test_back_to_back();
      test_abort();
      test_coincident();
      test_overrun();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pmod_als_spi_responder.md
# pmod_als_spi_responder

Synthesizable SPI responder emulating the Pmod ALS light-sensor ADC, driving `sdo` for the codebase's SPI master (mode: `sck` idles high, data sampled at the end of each `sck` low phase) so that designs can be tested without the physical Pmod. It sits on the pin side of the master: it takes `cs`/`sck` from the master (or from pins), synchronizes them, and shifts out a 16-bit frame built from an 8-bit light level supplied by the testbench or by switches. It also reports frame completion, aborted frames and over-clocked frames.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `cs` and `sck`; legal values 2..3.
- `clock`  in  1  system clock; every register is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cs`  in  1  chip select from the master, active low.
- `sck`  in  1  serial clock from the master; idles high.
- `light`  in  8  light level to report; latched at the start of each frame.
- `sdo`  out  1  serial data to the master; driven 0 whenever no bit is being presented.
- `busy`  out  1  high while a frame is active.
- `frame_done`  out  1  one-cycle pulse when `cs` rises after exactly 16 bits.
- `frame_abort`  out  1  one-cycle pulse when `cs` rises after fewer than 16 bits.
- `overrun`  out  1  sticky; set when a 17th falling `sck` edge arrives in one frame; cleared only by `reset`.

## Operation
- Frame word F[15:0] = {3'b000, light_latched[7:0], 5'b00000}, sent MSB first (F[15] first).
- `cs` and `sck` each pass through a SYNC_STAGES flop chain plus one history flop. Edges are detected on the synchronized signals only.
- States:
  - ARM: entered on reset. `sdo`=0. Moves to IDLE when synchronized `cs`=1. A frame already in progress at reset release is ignored.
  - IDLE: `sdo`=0, `busy`=0. On synchronized `cs` falling edge: latch `light` into `light_latched`, clear `bit_cnt` (5 bits), go to ACTIVE.
  - ACTIVE: `busy`=1. On each synchronized `sck` falling edge:
    - if `bit_cnt` < 16: `sdo` <= F[15-bit_cnt], then `bit_cnt`++.
    - otherwise: `sdo` <= 0 and set `overrun`.
  - Exit from ACTIVE on synchronized `cs` rising edge: `sdo` <= 0, pulse `frame_done` if `bit_cnt`==16, else pulse `frame_abort`, go to IDLE.
- `sdo`=0 from `cs` fall until the first `sck` fall. The master's 16 samples therefore read F[15..0].
- `cs` rise and `sck` fall in the same synchronized cycle: the `cs` rise wins. No bit is shifted, and `bit_cnt` is evaluated before any increment.
- `sck` edges seen while in IDLE or ARM are ignored.
- `light` changing during ACTIVE does not affect the current frame.

## Timing
- Reset values: `sdo`=0, `busy`=0, `frame_done`=0, `frame_abort`=0, `overrun`=0, `bit_cnt`=0, state ARM, all synchronizer flops 1 (the idle level).
- Let E be the first clock edge that samples the new raw pin level. Then `sdo`, `busy` and the pulses update at edge E+SYNC_STAGES+1.
- Requirement on the master: the `sck` low phase must be at least SYNC_STAGES+3 clocks. The codebase master (8-clock half period) satisfies this.
- `frame_done` and `frame_abort` are high for exactly one clock. `busy` falls on the same edge as either pulse.
- Back-to-back frames need `cs` high for at least SYNC_STAGES+1 clocks. Shorter pulses may be missed, and the responder stays in ACTIVE.

## Structure
- Shared package `pmod_als_pkg`:
  - constants `ALS_FRAME_BITS`=16, `ALS_LEAD_ZEROS`=3, `ALS_TRAIL_ZEROS`=5;
  - the state encoding ARM/IDLE/ACTIVE.
- Sub-module `pmod_sync`: a parameterized flop-chain synchronizer with a reset value input, instantiated once for `cs` and once for `sck`.

## Test plan
- Codebase master connected to the responder, `light`=8'hA5 → master `value`=16'h14A0; one `frame_done` pulse per frame; `overrun`=0.
- `light`=8'hFF, then 8'h00 changed mid-frame → the first frame reads 16'h1FE0; the next frame reads 16'h0000.
- Bench-driven `cs` rises after 9 `sck` falls → `frame_abort` pulses once, `frame_done` stays 0, `sdo`=0 afterwards, and the next full frame reads correctly.
- Bench drives 18 `sck` falls in one frame with `light`=8'h81 → bits 1..16 equal 16'h1020, bits 17..18 are 0, `overrun` sets and stays 1 after `cs` rises.
- `reset` asserted mid-frame (after bit 5) and released with `cs` still low → `sdo`=0 for the rest of that frame with no pulses; the following frame is normal.
- Same clock edge in the synchronized domain for `cs` rise and the 16th `sck` fall → `frame_abort` pulses (`bit_cnt`=15) and no 16th bit is driven.
